// File: rtl/aes_pkg.sv
// Shared types, constants and helpers for the AES-128 key expansion engine.
package aes_pkg;

  typedef logic [31:0]  aes_word_t;
  typedef logic [127:0] aes_key128_t;

  typedef enum logic [1:0] {
    IDLE,
    SUB,
    MIX
  } ks_state_t;

  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_POLY = 8'h1b;
  localparam int         NR_128    = 10;

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
  endfunction

  function automatic aes_word_t rot_word(input aes_word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box computed as GF(2^8) inversion (x^254) followed by the affine map.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] s
);

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = x;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  assign s = affine(gf_inv(a));

endmodule

// File: rtl/aes128_key_sched.sv
// Sequential AES-128 key expansion: one shared S-box, one SubWord byte per cycle,
// a new round key every 5 cycles.
module aes128_key_sched
  import aes_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [127:0] key_i,
  output logic        busy_o,
  output logic        rk_valid_o,
  output logic [127:0] rk_o,
  output logic [3:0]  rk_idx_o,
  output logic        done_o
);

  ks_state_t state_q, state_d;
  aes_word_t w0_q, w1_q, w2_q, w3_q, temp_q;
  aes_word_t rot_w3, w0_n, w1_n, w2_n, w3_n;
  logic [1:0] k_q;
  logic [3:0] round_q;
  logic [7:0] rcon_q;
  logic [7:0] sbox_in, sbox_out;
  logic       last_round;

  assign rot_w3     = rot_word(w3_q);
  assign last_round = (round_q == 4'(NR_128 - 1));

  always_comb begin
    sbox_in = rot_w3[31:24];
    case (k_q)
      2'd0: sbox_in = rot_w3[31:24];
      2'd1: sbox_in = rot_w3[23:16];
      2'd2: sbox_in = rot_w3[15:8];
      2'd3: sbox_in = rot_w3[7:0];
      default: sbox_in = rot_w3[31:24];
    endcase
  end

  aes_sbox u_sbox (
    .a(sbox_in),
    .s(sbox_out)
  );

  assign w0_n = w0_q ^ temp_q ^ {rcon_q, 24'h000000};
  assign w1_n = w1_q ^ w0_n;
  assign w2_n = w2_q ^ w1_n;
  assign w3_n = w3_q ^ w2_n;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = SUB;
      SUB:     if (k_q == 2'd3) state_d = MIX;
      MIX:     state_d = last_round ? IDLE : SUB;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      w0_q       <= '0;
      w1_q       <= '0;
      w2_q       <= '0;
      w3_q       <= '0;
      temp_q     <= '0;
      k_q        <= 2'd0;
      round_q    <= 4'd0;
      rcon_q     <= RCON_INIT;
      busy_o     <= 1'b0;
      rk_valid_o <= 1'b0;
      rk_o       <= '0;
      rk_idx_o   <= 4'd0;
      done_o     <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_o     <= (state_d != IDLE);
      rk_valid_o <= 1'b0;
      done_o     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            {w0_q, w1_q, w2_q, w3_q} <= key_i;
            rcon_q     <= RCON_INIT;
            round_q    <= 4'd0;
            k_q        <= 2'd0;
            rk_o       <= key_i;
            rk_idx_o   <= 4'd0;
            rk_valid_o <= 1'b1;
          end
        end
        SUB: begin
          case (k_q)
            2'd0: temp_q[31:24] <= sbox_out;
            2'd1: temp_q[23:16] <= sbox_out;
            2'd2: temp_q[15:8]  <= sbox_out;
            default: temp_q[7:0] <= sbox_out;
          endcase
          k_q <= k_q + 2'd1;
        end
        MIX: begin
          {w0_q, w1_q, w2_q, w3_q} <= {w0_n, w1_n, w2_n, w3_n};
          round_q    <= round_q + 4'd1;
          rcon_q     <= xtime(rcon_q);
          k_q        <= 2'd0;
          rk_o       <= {w0_n, w1_n, w2_n, w3_n};
          rk_idx_o   <= round_q + 4'd1;
          rk_valid_o <= 1'b1;
          done_o     <= last_round;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_key_sched.sv
// Scoreboard bench for aes128_key_sched using FIPS-197 and all-zero key vectors.
module tb_aes128_key_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_i;
  logic [127:0] key_i;
  logic         busy_o;
  logic         rk_valid_o;
  logic [127:0] rk_o;
  logic [3:0]   rk_idx_o;
  logic         done_o;

  aes128_key_sched dut (
    .clk(clk),
    .rst(rst),
    .start_i(start_i),
    .key_i(key_i),
    .busy_o(busy_o),
    .rk_valid_o(rk_valid_o),
    .rk_o(rk_o),
    .rk_idx_o(rk_idx_o),
    .done_o(done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] key;
    logic [3:0]   idx;
    logic         done;
    logic         chk;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic [127:0] a1_rk [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: every rk_valid_o pulse is matched against the head of the scoreboard.
  always @(negedge clk) begin
    if (done_o && !rk_valid_o) check("done_without_valid", 128'(done_o), 128'(0));
    if (rk_valid_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: idx %0d at cycle %0d, no pulse expected", rk_idx_o, cyc);
      end else begin
        e = sb.pop_front();
        check("rk_idx", 128'(rk_idx_o), 128'(e.idx));
        check("rk_cycle", 128'(cyc), 128'(e.cyc));
        check("rk_done", 128'(done_o), 128'(e.done));
        if (e.chk) check("rk_key", rk_o, e.key);
      end
    end
  end

  task automatic push_run(input int n0, input bit zero_key);
    exp_t x;
    for (int r = 0; r <= 10; r++) begin
      x.idx  = 4'(r);
      x.done = (r == 10);
      x.cyc  = n0 + 5 * r;
      if (zero_key) begin
        x.chk = (r == 0 || r == 1 || r == 10);
        x.key = (r == 1)  ? 128'h62636363626363636263636362636363 :
                (r == 10) ? 128'hb4ef5bcb3e92e21123e951cf6f8f188e : 128'h0;
      end else begin
        x.chk = 1'b1;
        x.key = a1_rk[r];
      end
      sb.push_back(x);
    end
  endtask

  task automatic start_run(input logic [127:0] key, input bit zero_key);
    key_i   = key;
    start_i = 1'b1;
    push_run(cyc + 1, zero_key);
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 128'(sb.size()), 128'(0));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, 128'(busy_o), 128'(0));
    check({tag, "_rk_valid"}, 128'(rk_valid_o), 128'(0));
    check({tag, "_done"}, 128'(done_o), 128'(0));
    check({tag, "_rk"}, rk_o, 128'(0));
    check({tag, "_rk_idx"}, 128'(rk_idx_o), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst     = 1'b1;
    start_i = 1'b0;
    key_i   = '0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // A.1 key, with busy profile and a start pulse mid-run that must be ignored.
    start_run(KEY_A1, 1'b0);
    n = cyc;
    check("busy_after_start", 128'(busy_o), 128'(1));
    wait_cyc(n + 10);
    key_i   = '0;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_cyc(n + 49);
    check("busy_late", 128'(busy_o), 128'(1));
    wait_cyc(n + 50);
    check("busy_in_done_cycle", 128'(busy_o), 128'(0));
    wait_drain(80);
    repeat (4) @(negedge clk);

    // All-zero key.
    start_run(128'h0, 1'b1);
    wait_drain(80);
    repeat (3) @(negedge clk);

    // start_i held high: second run accepted right after done with no gap.
    key_i   = KEY_A1;
    start_i = 1'b1;
    n = cyc + 1;
    push_run(n, 1'b0);
    push_run(n + 51, 1'b1);
    wait_cyc(n + 50);
    key_i = '0;
    wait_cyc(n + 55);
    start_i = 1'b0;
    wait_drain(120);
    repeat (3) @(negedge clk);

    // key_i changes right after acceptance must not affect the schedule.
    start_run(KEY_A1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      key_i = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
    end
    wait_drain(80);
    repeat (3) @(negedge clk);

    // Asynchronous reset just after E23 of a run.
    start_run(KEY_A1, 1'b0);
    n = cyc;
    wait_cyc(n + 22);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check_outputs_zero("async_reset");
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("busy_after_abort", 128'(busy_o), 128'(0));
    start_run(KEY_A1, 1'b0);
    wait_drain(80);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
